// File: rtl/pipe_wb_regfile.sv
// pipe_wb_regfile: writeback stage and architectural register file.
//   Selects the writeback data from the MEM/WB staged values, commits it to a
//   32-entry register file (x0 hardwired to zero), serves two combinational read
//   ports to ID, and counts committed register writes.
// Optional feature (macro WB_RF_BYPASS_EN): write-through bypass on the read ports.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_alu_out/dmem_out/pc4/rs_data_out  writeback data sources
//   wb_rf_waddr/wena/mux_sel destination index, write enable, source select
//   id_raddr1/2, id_rdata1/2 read port indices and data
//   wb_wdata                 selected writeback data (for forwarding)
//   rf_write_cnt             number of committed register writes (wraps)
module pipe_wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_alu_out,
  input  logic [DATA_W-1:0] wb_dmem_out,
  input  logic [DATA_W-1:0] wb_pc4,
  input  logic [DATA_W-1:0] wb_rs_data_out,
  input  logic [4:0]        wb_rf_waddr,
  input  logic              wb_rf_wena,
  input  logic [2:0]        wb_rf_mux_sel,
  input  logic [4:0]        id_raddr1,
  input  logic [4:0]        id_raddr2,
  output logic [DATA_W-1:0] id_rdata1,
  output logic [DATA_W-1:0] id_rdata2,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [CNT_W-1:0]  rf_write_cnt
);

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_valid;

  // Reserved selects fall back to the ALU result so the output is always defined.
  always_comb begin
    case (wb_rf_mux_sel)
      3'd1:    wb_wdata = wb_dmem_out;
      3'd2:    wb_wdata = wb_pc4;
      3'd3:    wb_wdata = wb_rs_data_out;
      default: wb_wdata = wb_alu_out;
    endcase
  end

  // Write request ignoring reset; reused by the bypass path, which stays live in reset.
  assign wr_valid = wb_rf_wena && (wb_rf_waddr != 5'd0);

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_d[i] = '0;
      end
      cnt_d = '0;
    end else if (wr_valid) begin
      regs_d[wb_rf_waddr] = wb_wdata;
      cnt_d               = cnt_q + CNT_W'(1);
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
    cnt_q  <= cnt_d;
  end

  always_comb begin
    id_rdata1 = (id_raddr1 == 5'd0) ? '0 : regs_q[id_raddr1];
    id_rdata2 = (id_raddr2 == 5'd0) ? '0 : regs_q[id_raddr2];
`ifdef WB_RF_BYPASS_EN
    // wr_valid already excludes index 0, so x0 is never bypassed.
    if (wr_valid && (id_raddr1 == wb_rf_waddr)) id_rdata1 = wb_wdata;
    if (wr_valid && (id_raddr2 == wb_rf_waddr)) id_rdata2 = wb_wdata;
`endif
  end

  assign rf_write_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_wb_regfile.sv
module tb_pipe_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_alu_out, wb_dmem_out, wb_pc4, wb_rs_data_out;
  logic [4:0]  wb_rf_waddr;
  logic        wb_rf_wena;
  logic [2:0]  wb_rf_mux_sel;
  logic [4:0]  id_raddr1, id_raddr2;
  logic [31:0] id_rdata1, id_rdata2, wb_wdata;
  logic [31:0] rf_write_cnt;
  logic [31:0] n_rdata1, n_rdata2, n_wdata;
  logic [3:0]  n_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_wb_regfile #(.DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .wb_alu_out(wb_alu_out), .wb_dmem_out(wb_dmem_out), .wb_pc4(wb_pc4),
    .wb_rs_data_out(wb_rs_data_out), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wena(wb_rf_wena),
    .wb_rf_mux_sel(wb_rf_mux_sel), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .wb_wdata(wb_wdata),
    .rf_write_cnt(rf_write_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap scenario.
  pipe_wb_regfile #(.DATA_W(32), .CNT_W(4)) dut_n (
    .clk(clk), .rst(rst),
    .wb_alu_out(wb_alu_out), .wb_dmem_out(wb_dmem_out), .wb_pc4(wb_pc4),
    .wb_rs_data_out(wb_rs_data_out), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wena(wb_rf_wena),
    .wb_rf_mux_sel(wb_rf_mux_sel), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
    .id_rdata1(n_rdata1), .id_rdata2(n_rdata2), .wb_wdata(n_wdata),
    .rf_write_cnt(n_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_rf_wena = 1'b1; wb_rf_waddr = 5'd5; wb_rf_mux_sel = 3'd0;
    wb_alu_out = 32'h5555_5555; wb_dmem_out = '0; wb_pc4 = '0; wb_rs_data_out = '0;
    id_raddr1 = 5'd5; id_raddr2 = 5'd0;
    tick();
    tick();
    rst = 1'b0; wb_rf_wena = 1'b0;
    #1;
    checks++;
    if (id_rdata1 !== 32'h0) begin
      errors++; $display("FAIL reset_reg5: got %h expected %h", id_rdata1, 32'h0);
    end
    checks++;
    if (id_rdata2 !== 32'h0) begin
      errors++; $display("FAIL reset_reg0: got %h expected %h", id_rdata2, 32'h0);
    end
    checks++;
    if (rf_write_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", rf_write_cnt);
    end
    checks++;
    if (n_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_cnt_narrow: got %0d expected 0", n_cnt);
    end
  endtask

  task automatic test_source_select();
    logic [2:0]  sels [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    logic [31:0] exps [5] = '{32'h1111_1111, 32'h2222_2222, 32'h0040_0008,
                              32'h4444_4444, 32'h1111_1111};
    wb_alu_out = 32'h1111_1111; wb_dmem_out = 32'h2222_2222;
    wb_pc4 = 32'h0040_0008; wb_rs_data_out = 32'h4444_4444;
    wb_rf_waddr = 5'd3; id_raddr1 = 5'd3;
    for (int i = 0; i < 5; i++) begin
      wb_rf_mux_sel = sels[i]; wb_rf_wena = 1'b1;
      #1;
      checks++;
      if (wb_wdata !== exps[i]) begin
        errors++; $display("FAIL sel_wdata[%0d]: got %h expected %h", i, wb_wdata, exps[i]);
      end
      tick();
      wb_rf_wena = 1'b0;
      #1;
      checks++;
      if (id_rdata1 !== exps[i]) begin
        errors++; $display("FAIL sel_reg3[%0d]: got %h expected %h", i, id_rdata1, exps[i]);
      end
    end
    checks++;
    if (rf_write_cnt !== 32'd5) begin
      errors++; $display("FAIL sel_cnt: got %0d expected 5", rf_write_cnt);
    end
  endtask

  task automatic test_reg0();
    wb_rf_wena = 1'b1; wb_rf_waddr = 5'd0; wb_rf_mux_sel = 3'd0;
    wb_alu_out = 32'hDEAD_BEEF; id_raddr1 = 5'd0;
    #1;
    checks++;
    if (id_rdata1 !== 32'h0) begin
      errors++; $display("FAIL reg0_same_cycle: got %h expected %h", id_rdata1, 32'h0);
    end
    tick();
    wb_rf_wena = 1'b0;
    #1;
    checks++;
    if (id_rdata1 !== 32'h0) begin
      errors++; $display("FAIL reg0_after: got %h expected %h", id_rdata1, 32'h0);
    end
    checks++;
    if (rf_write_cnt !== 32'd5) begin
      errors++; $display("FAIL reg0_cnt: got %0d expected 5", rf_write_cnt);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_now;
    wb_rf_wena = 1'b1; wb_rf_waddr = 5'd7; wb_rf_mux_sel = 3'd0;
    wb_alu_out = 32'hAAAA_0000;
    tick();
    wb_alu_out = 32'h1234_5678; id_raddr1 = 5'd7; id_raddr2 = 5'd7;
    #1;
`ifdef WB_RF_BYPASS_EN
    exp_now = 32'h1234_5678;
`else
    exp_now = 32'hAAAA_0000;
`endif
    checks++;
    if (id_rdata1 !== exp_now) begin
      errors++; $display("FAIL rw_port1_now: got %h expected %h", id_rdata1, exp_now);
    end
    checks++;
    if (id_rdata2 !== exp_now) begin
      errors++; $display("FAIL rw_port2_now: got %h expected %h", id_rdata2, exp_now);
    end
    tick();
    wb_rf_wena = 1'b0;
    #1;
    checks++;
    if (id_rdata1 !== 32'h1234_5678 || id_rdata2 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL rw_next: got %h/%h expected %h", id_rdata1, id_rdata2, 32'h1234_5678);
    end
    checks++;
    if (rf_write_cnt !== 32'd7) begin
      errors++; $display("FAIL rw_cnt: got %0d expected 7", rf_write_cnt);
    end
  endtask

  task automatic test_write_disabled();
    wb_rf_wena = 1'b0; wb_rf_waddr = 5'd9; wb_rf_mux_sel = 3'd0;
    wb_alu_out = 32'hFFFF_FFFF; id_raddr1 = 5'd9;
    #1;
    checks++;
    if (wb_wdata !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wdis_wdata: got %h expected %h", wb_wdata, 32'hFFFF_FFFF);
    end
    tick();
    checks++;
    if (id_rdata1 !== 32'h0) begin
      errors++; $display("FAIL wdis_reg9: got %h expected %h", id_rdata1, 32'h0);
    end
    checks++;
    if (rf_write_cnt !== 32'd7) begin
      errors++; $display("FAIL wdis_cnt: got %0d expected 7", rf_write_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    rst = 1'b1; wb_rf_wena = 1'b0;
    tick();
    rst = 1'b0; wb_rf_wena = 1'b1; wb_rf_waddr = 5'd1; wb_rf_mux_sel = 3'd0;
    id_raddr1 = 5'd1;
    for (int i = 0; i < 17; i++) begin
      wb_alu_out = 32'h100 + 32'(i);
      tick();
      if (i == 15) begin
        checks++;
        if (n_cnt !== 4'd0) begin
          errors++; $display("FAIL wrap_at16: got %0d expected 0", n_cnt);
        end
      end
    end
    wb_rf_wena = 1'b0;
    #1;
    checks++;
    if (n_cnt !== 4'd1) begin
      errors++; $display("FAIL wrap_cnt17: got %0d expected 1", n_cnt);
    end
    checks++;
    if (rf_write_cnt !== 32'd17) begin
      errors++; $display("FAIL wide_cnt17: got %0d expected 17", rf_write_cnt);
    end
    checks++;
    if (n_rdata1 !== 32'h110) begin
      errors++; $display("FAIL wrap_reg1: got %h expected %h", n_rdata1, 32'h110);
    end
    // Mid-sequence reset while a write is in flight.
    wb_rf_wena = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (n_cnt !== 4'd4) begin
      errors++; $display("FAIL pre_rst_cnt: got %0d expected 4", n_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; wb_rf_wena = 1'b0;
    #1;
    checks++;
    if (n_cnt !== 4'd0 || rf_write_cnt !== 32'd0) begin
      errors++; $display("FAIL mid_rst_cnt: got %0d/%0d expected 0/0", n_cnt, rf_write_cnt);
    end
    checks++;
    if (id_rdata1 !== 32'h0) begin
      errors++; $display("FAIL mid_rst_reg1: got %h expected %h", id_rdata1, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_source_select();
    test_reg0();
    test_same_cycle();
    test_write_disabled();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
